// File: rtl/vid_pixel_pkg.sv
// Shared types and helpers for the pixel unpacker.
// Provides the bits-per-pixel enum, its width decode and the identity palette seed.
// No ports; imported by vid_fetch_fifo and vid_pixel_unpacker.
package vid_pixel_pkg;

  typedef enum logic [1:0] {
    BPP1 = 2'd0,
    BPP2 = 2'd1,
    BPP4 = 2'd2
  } bpp_e;

  // The reserved encoding 3 falls back to 1bpp.
  function automatic bpp_e bpp_decode(logic [1:0] sel);
    case (sel)
      2'd1:    return BPP2;
      2'd2:    return BPP4;
      default: return BPP1;
    endcase
  endfunction

  function automatic logic [2:0] bpp_bits(bpp_e b);
    case (b)
      BPP2:    return 3'd2;
      BPP4:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Identity palette seed: entry i holds colour i.
  function automatic logic [7:0] pal_ident(int unsigned i);
    return 8'(i);
  endfunction

endpackage

// File: rtl/vid_fetch_fifo.sv
// Small synchronous FIFO buffering VRAM fetch words ahead of the pixel shifter.
// Ports: clk/reset, push_i+data_i write side, pop_i read side with data_o as
// the combinational head word, full_o/empty_o status. Pushes when full and pops when empty are ignored.
module vid_fetch_fifo
  import vid_pixel_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vid_pixel_unpacker.sv
// Serialises packed VRAM words at 1/2/4 bpp (MSB first), maps through a palette, drives border outside display.
// Ports: fetch_* valid/ready input into FIFO; pix_ce/bpp_sel/display_enable/border_color control;
// pal_* palette write; video registered colour; underrun sticky. Optional pix_double via VID_PIX_DOUBLE_EN.
module vid_pixel_unpacker
  import vid_pixel_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int COLOR_W    = 4,
  parameter int PAL_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [1:0]         bpp_sel,
  input  logic [WORD_W-1:0]  fetch_data,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic               display_enable,
  input  logic [COLOR_W-1:0] border_color,
  input  logic               pal_we,
  input  logic [COLOR_W-1:0] pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata,
`ifdef VID_PIX_DOUBLE_EN
  input  logic               pix_double,
`endif
  output logic [COLOR_W-1:0] video,
  output logic               underrun
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0]  fifo_head;
  logic               fifo_full, fifo_empty;

  logic [WORD_W-1:0]  sh_q, sh_d, src_word;
  logic [CW-1:0]      cnt_q, cnt_d, src_cnt;
  bpp_e               bpp_q, bpp_d;
  logic               de_q;
  logic [COLOR_W-1:0] video_q, video_d;
  logic               underrun_q;
  logic [COLOR_W-1:0] pal_q [PAL_DEPTH];

  logic               load, emit, starve, line_end, advance;
  logic [2:0]         nbits;
  logic [3:0]         idx4;
  logic [COLOR_W-1:0] pix_idx;

`ifdef VID_PIX_DOUBLE_EN
  logic phase_q, phase_d;
`endif

  assign fetch_ready = !fifo_full;

  vid_fetch_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fetch_valid),
    .data_i  (fetch_data),
    .pop_i   (load),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // Words are only pulled when a pixel is actually needed, so the FIFO
    // fills up during blanking instead of draining into the shifter.
    load     = pix_ce && display_enable && (cnt_q == '0) && !fifo_empty;
    emit     = pix_ce && display_enable && ((cnt_q != '0) || !fifo_empty);
    starve   = pix_ce && display_enable && (cnt_q == '0) && fifo_empty;
    line_end = pix_ce && de_q && !display_enable;

    // A freshly loaded word is emitted from in the same cycle.
    src_word = load ? fifo_head : sh_q;
    src_cnt  = load ? CW'(WORD_W) : cnt_q;
    bpp_d    = load ? bpp_decode(bpp_sel) : bpp_q;
    nbits    = bpp_bits(bpp_d);

    case (bpp_d)
      BPP2:    idx4 = {2'b00, src_word[WORD_W-1 -: 2]};
      BPP4:    idx4 = src_word[WORD_W-1 -: 4];
      default: idx4 = {3'b000, src_word[WORD_W-1]};
    endcase
    pix_idx = COLOR_W'(idx4);

`ifdef VID_PIX_DOUBLE_EN
    // Phase counts as 0 on a load; the word advances only on the second
    // pix_ce of each doubled pixel.
    advance = emit && (!pix_double || (!load && phase_q));
    phase_d = phase_q;
    if (line_end)
      phase_d = 1'b0;
    else if (emit)
      phase_d = pix_double ? (load ? 1'b1 : !phase_q) : 1'b0;
`else
    advance = emit;
`endif

    sh_d  = advance ? (src_word << nbits) : src_word;
    cnt_d = advance ? (src_cnt - CW'(nbits)) : src_cnt;
    if (line_end) cnt_d = '0;

    video_d = emit ? pal_q[pix_idx] : border_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      bpp_q      <= BPP1;
      de_q       <= 1'b0;
      video_q    <= '0;
      underrun_q <= 1'b0;
    end else if (pix_ce) begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bpp_q   <= bpp_d;
      de_q    <= display_enable;
      video_q <= video_d;
      if (starve) underrun_q <= 1'b1;
    end
  end

`ifdef VID_PIX_DOUBLE_EN
  always_ff @(posedge clk) begin
    if (reset)       phase_q <= 1'b0;
    else if (pix_ce) phase_q <= phase_d;
  end
`endif

  // Palette reads above see the pre-write value in a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= COLOR_W'(pal_ident(i));
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_wdata;
    end
  end

  assign video    = video_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vid_pixel_unpacker.sv
module tb_vid_pixel_unpacker;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int COLOR_W    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               pix_ce;
  logic [1:0]         bpp_sel;
  logic [WORD_W-1:0]  fetch_data;
  logic               fetch_valid;
  logic               fetch_ready;
  logic               display_enable;
  logic [COLOR_W-1:0] border_color;
  logic               pal_we;
  logic [COLOR_W-1:0] pal_addr;
  logic [COLOR_W-1:0] pal_wdata;
  logic [COLOR_W-1:0] video;
  logic               underrun;
`ifdef VID_PIX_DOUBLE_EN
  logic               pix_double;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state: FIFO of words, queue of pending pixel indices.
  logic [WORD_W-1:0]  m_fq [$];
  logic [3:0]         m_pix [$];
  logic [3:0]         m_pal [16];
  logic [3:0]         m_video;
  logic               m_under;
  logic               m_de_prev;

  always #5 clk = ~clk;

  vid_pixel_unpacker #(
    .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .COLOR_W(COLOR_W), .PAL_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .bpp_sel(bpp_sel),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .display_enable(display_enable), .border_color(border_color),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
`ifdef VID_PIX_DOUBLE_EN
    .pix_double(pix_double),
`endif
    .video(video), .underrun(underrun)
  );

  function automatic int bits_of(logic [1:0] s);
    case (s)
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 1;
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    logic [WORD_W-1:0] w;
    logic [3:0]        idx;
    logic              pre_ready;
    int                b;
    if (reset) begin
      m_fq.delete();
      m_pix.delete();
      for (int i = 0; i < 16; i++) m_pal[i] = 4'(i);
      m_video   = '0;
      m_under   = 1'b0;
      m_de_prev = 1'b0;
      return;
    end
    pre_ready = (m_fq.size() < FIFO_DEPTH);
    if (pix_ce) begin
      if (display_enable) begin
        if (m_pix.size() == 0 && m_fq.size() != 0) begin
          w = m_fq.pop_front();
          b = bits_of(bpp_sel);
          for (int k = 0; k < WORD_W / b; k++) begin
            idx = 4'((w >> (WORD_W - b * (k + 1))) & ((1 << b) - 1));
            m_pix.push_back(idx);
`ifdef VID_PIX_DOUBLE_EN
            if (pix_double) m_pix.push_back(idx);
`endif
          end
        end
        if (m_pix.size() != 0) begin
          m_video = m_pal[m_pix.pop_front()];
        end else begin
          m_video = border_color;
          m_under = 1'b1;
        end
      end else begin
        m_video = border_color;
        if (m_de_prev) m_pix.delete();
      end
      m_de_prev = display_enable;
    end
    if (fetch_valid && pre_ready) m_fq.push_back(fetch_data);
    if (pal_we) m_pal[pal_addr] = pal_wdata;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: update the model, let the edge happen, compare away from the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("video", 16'(video), 16'(m_video));
    chk("underrun", 16'(underrun), 16'(m_under));
    chk("fetch_ready", 16'(fetch_ready), 16'(m_fq.size() < FIFO_DEPTH));
  endtask

  int exp1 [16] = '{1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0};
  int exp2 [8]  = '{0,1,12,3,0,0,0,0};
  int len;

  initial begin
    reset = 1'b1; pix_ce = 1'b1; bpp_sel = 2'd0; fetch_data = '0; fetch_valid = 1'b0;
    display_enable = 1'b0; border_color = '0; pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
`ifdef VID_PIX_DOUBLE_EN
    pix_double = 1'b0;
`endif
    @(negedge clk);
    step(); step();
    chk("rst_video", 16'(video), 16'h0);
    chk("rst_underrun", 16'(underrun), 16'h0);
    chk("rst_ready", 16'(fetch_ready), 16'h1);
    reset = 1'b0;

    // 1bpp, identity palette.
    fetch_valid = 1'b1; fetch_data = 16'hA5F0; step(); fetch_valid = 1'b0;
    display_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin step(); chk("t1_pix", 16'(video), 16'(exp1[i])); end
    display_enable = 1'b0; step();

    // 2bpp with palette[2] rewritten, then restored.
    bpp_sel = 2'd1; pal_we = 1'b1; pal_addr = 4'd2; pal_wdata = 4'hC;
    fetch_valid = 1'b1; fetch_data = 16'h1B00; step(); fetch_valid = 1'b0; pal_we = 1'b0;
    display_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); chk("t2_pix", 16'(video), 16'(exp2[i])); end
    display_enable = 1'b0; pal_we = 1'b1; pal_wdata = 4'h2; step(); pal_we = 1'b0;

    // 4bpp: three words offered while blanked; FIFO fills at two.
    bpp_sel = 2'd2; fetch_valid = 1'b1;
    fetch_data = 16'h1234; step();
    fetch_data = 16'h5678; step();
    chk("t4_full", 16'(fetch_ready), 16'h0);
    fetch_data = 16'h9ABC; step();
    chk("t4_hold", 16'(fetch_ready), 16'h0);
    display_enable = 1'b1;
    step(); chk("t4_pix", 16'(video), 16'h1);
    chk("t4_ready_back", 16'(fetch_ready), 16'h1);
    step(); chk("t4_pix", 16'(video), 16'h2);
    fetch_valid = 1'b0;
    for (int i = 2; i < 12; i++) begin step(); chk("t4_pix", 16'(video), 16'(i + 1)); end
    display_enable = 1'b0; step();

    // Starvation: border shown, sticky underrun, cleared only by reset.
    border_color = 4'h9; bpp_sel = 2'd0; display_enable = 1'b1; step();
    chk("t5_border", 16'(video), 16'h9);
    chk("t5_underrun", 16'(underrun), 16'h1);
    fetch_valid = 1'b1; fetch_data = 16'hFFFF; step(); fetch_valid = 1'b0;
    step(); chk("t5_pix", 16'(video), 16'h1);
    chk("t5_sticky", 16'(underrun), 16'h1);
    display_enable = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    chk("t5_cleared", 16'(underrun), 16'h0);
    chk("t5_rst_video", 16'(video), 16'h0);

    // Line end discards residual bits; next line starts on the next word.
    border_color = 4'h0; fetch_valid = 1'b1;
    fetch_data = 16'hF800; step();
    fetch_data = 16'h8000; step();
    fetch_valid = 1'b0; display_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); chk("t6_pix", 16'(video), 16'h1); end
    display_enable = 1'b0; step();
    display_enable = 1'b1;
    step(); chk("t6_next_msb", 16'(video), 16'h1);
    step(); chk("t6_next_2nd", 16'(video), 16'h0);
    display_enable = 1'b0; reset = 1'b1; step(); reset = 1'b0;

`ifdef VID_PIX_DOUBLE_EN
    pix_double = 1'b1; bpp_sel = 2'd2; fetch_valid = 1'b1; fetch_data = 16'h1234; step();
    fetch_valid = 1'b0; display_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); chk("dbl_pix", 16'(video), 16'(i / 2 + 1)); end
    display_enable = 1'b0; step(); pix_double = 1'b0;
`endif

    // Random traffic against the model, with one mid-line reset.
    len = 0;
    for (int c = 0; c < 1500; c++) begin
      if (len == 0) begin
        display_enable = !display_enable;
        len = $urandom_range(3, 40);
      end
      len--;
      pix_ce       = ($urandom_range(0, 3) != 0);
      fetch_valid  = $urandom_range(0, 1);
      fetch_data   = 16'($urandom);
      bpp_sel      = 2'($urandom_range(0, 3));
      border_color = 4'($urandom);
      pal_we       = ($urandom_range(0, 7) == 0);
      pal_addr     = 4'($urandom);
      pal_wdata    = 4'($urandom);
      reset        = (c == 700);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vid_pixel_unpacker.md
Name: vid_pixel_unpacker

Overview:
- Parametrised successor to the fixed CGA/Tandy pixel path.
- Accepts packed VRAM fetch words through a valid/ready handshake into a small FIFO, then serialises them at 1, 2 or 4 bits per pixel, MSB first.
- Maps each pixel index through a programmable palette and drives the border colour outside the active display.
- Sits between the VRAM fetch sequencer and the final video/sync output stage.

Parameters:
- WORD_W, 16, fetch word width in bits; must be a multiple of 4.
- FIFO_DEPTH, 2, number of fetch words buffered; power of two, at least 2.
- COLOR_W, 4, output colour width and palette entry width.
- PAL_DEPTH, 16, number of palette entries; must equal 2**COLOR_W.

Ports:
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; all pixel-path state advances only when pix_ce=1.
- bpp_sel  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=reserved (treated as 1bpp).
- fetch_data  in  WORD_W  packed pixel word from VRAM.
- fetch_valid  in  1  fetch_data is valid.
- fetch_ready  out  1  FIFO can accept a word.
- display_enable  in  1  active display region.
- border_color  in  COLOR_W  colour driven when not displaying.
- pal_we  in  1  palette write strobe; independent of pix_ce.
- pal_addr  in  COLOR_W  palette write address.
- pal_wdata  in  COLOR_W  palette write data.
- video  out  COLOR_W  registered pixel colour.
- underrun  out  1  sticky flag; set when a pixel is needed and no data is available.

Behaviour:
- Reset:
  - FIFO is emptied; fetch_ready=1.
  - Shifter is emptied (bit count 0).
  - video=0, underrun=0.
  - Palette is reset to identity: entry i = i.
- FIFO handshake:
  - A word is accepted when fetch_valid && fetch_ready on any clk edge; pix_ce is not required.
  - fetch_ready = !full.
  - A simultaneous push and pop when full is not allowed; ready is deasserted when full.
  - A push and pop in the same cycle when not full: the count is unchanged.
- Shifter load:
  - On pix_ce, when the shifter has 0 bits remaining and the FIFO is non-empty, the head word is popped into the shifter.
  - bpp_sel is latched at load. A bpp change mid-word takes effect at the next load.
- Shifting:
  - On each pix_ce with display_enable=1 and the shifter non-empty, the top bpp bits are emitted as a pixel index, zero-extended to COLOR_W.
  - The shifter shifts left by bpp and the remaining count decreases by bpp.
  - A word therefore yields WORD_W/bpp pixels.
  - Load and emit happen in the same pix_ce: the first pixel of a freshly loaded word is emitted on its load cycle.
- Output:
  - video is registered on pix_ce: palette[index] when display_enable=1 and a pixel is emitted, else border_color.
  - Latency: one pix_ce from display_enable/shift to video.
- Underrun:
  - On a pix_ce with display_enable=1, an empty shifter and an empty FIFO: video=border_color and underrun is set.
  - underrun stays set until reset.
- Line end:
  - On the pix_ce where display_enable falls (detected against a registered copy), residual shifter bits are discarded (count set to 0).
  - FIFO contents are kept.
- Palette:
  - Written on pal_we at any clk edge.
  - A write to the entry being read in the same cycle: video uses the old value; the new value applies from the next pix_ce.
- Reset mid-line: all state returns to reset values in the same cycle; the next accepted word starts fresh.

Optional Feature:
- Macro: VID_PIX_DOUBLE_EN.
- When defined: adds input pix_double. When pix_double=1, each emitted pixel is held for two pix_ce (a halved shift rate for 160-wide modes), using an internal phase bit cleared at load and at reset.
- When undefined: no pix_double port; one pixel per pix_ce.

Decomposition:
- Package vid_pixel_pkg holds:
  - the bpp_e enum (BPP1, BPP2, BPP4);
  - the function bpp_bits(bpp_e);
  - the identity-palette reset constant generator.
- Sub-module vid_fetch_fifo (parametrised WORD_W/FIFO_DEPTH, synchronous reset, full/empty/count) is natural.
- The shifter, palette and output register stay in the top module.

Test Plan:
- Identity palette, 1bpp, push word 16'hA5F0, display_enable=1 for 16 pix_ce -> video sequence 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, one pix_ce after each shift.
- 2bpp, word 16'h1B00 -> indices 0,1,2,3,0,0,0,0. Write palette[2]=4'hC beforehand -> the third pixel is 4'hC.
- 4bpp, FIFO_DEPTH=2: hold fetch_valid=1 with 3 words while display_enable=0 -> fetch_ready drops after 2 pushes. Enable display -> 4 pixels per word, no gap between words, ready reasserts after the first pop.
- Starve the FIFO: display_enable=1 with no data -> video=border_color (e.g. 4'h9), underrun=1, still 1 after data arrives. Reset clears it.
- Drop display_enable after 5 pixels of a 1bpp word -> residual 11 bits discarded; the next line starts with the next FIFO word's MSB.
- With VID_PIX_DOUBLE_EN and pix_double=1, 4bpp word 16'h1234 -> video 1,1,2,2,3,3,4,4.
